// File: rtl/hermes_boundary_ejector.sv
// hermes_boundary_ejector
//
// Receive-side endpoint for one Hermes mesh boundary port. It takes
// credit-flow-controlled flits leaving the mesh and frames them into packets.
// It can optionally filter packets on their target address. Surviving flits
// are queued in a small FIFO and presented on a valid/ready stream, with each
// flit tagged as start-of-packet or end-of-packet.
//
// Packet format: header (target in bits [15:0]), size N, then N payload flits.
//
// Compile-time option:
//   EJECTOR_ADDR_CHECK_EN - when defined, headers whose target differs from
//                           ADDR are consumed silently and counted in
//                           err_cnt_o. When undefined, every packet is
//                           delivered and err_cnt_o reads 0.
//
// Parameters:
//   FLIT_SIZE   - flit width in bits (must be at least 16)
//   BUFFER_SIZE - FIFO depth in flits; a power of two, at least 2
//   ADDR        - address of the boundary router this ejector stands for
//
// Ports:
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset
//   rx_i       in   flit valid from the mesh port
//   data_i     in   flit from the mesh port
//   credit_o   out  FIFO has room; the mesh may send while high
//   valid_o    out  output flit valid
//   ready_i    in   downstream accepts the output flit
//   data_o     out  output flit (0 while the FIFO is empty)
//   sop_o      out  data_o is a header flit
//   eop_o      out  data_o is the last flit of its packet
//   pkt_cnt_o  out  packets written to the FIFO; wraps around
//   err_cnt_o  out  packets dropped on address mismatch; saturates

module hermes_boundary_ejector #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned BUFFER_SIZE = 8,
    parameter logic [15:0] ADDR        = 16'h0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic [15:0]          pkt_cnt_o,
    output logic [15:0]          err_cnt_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned ENT_W = FLIT_SIZE + 2;

    typedef logic [FLIT_SIZE-1:0] flit_t;
    typedef logic [PTR_W:0]       count_t;

    localparam count_t FULL_COUNT = count_t'(BUFFER_SIZE);

`ifdef EJECTOR_ADDR_CHECK_EN
    typedef enum logic [2:0] {
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD,
        ST_DROP_SIZE,
        ST_DROP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD
    } state_t;
`endif

    // FIFO storage: each entry is {sop, eop, flit}.
    logic [ENT_W-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    count_t           count;
    logic [ENT_W-1:0] head;

    logic             full;
    logic             accept;
    logic             rd_en;

    // Parser state and the outputs of the parser's next-state logic.
    state_t           state;
    state_t           state_next;
    flit_t            remaining;
    logic             wr_en;
    logic             wr_sop;
    logic             wr_eop;
    logic             rem_load;
    logic             rem_dec;
    logic             pkt_inc;
    logic             err_inc;
    logic             size_zero;
    logic             rem_last;

    // Credit comes only from the registered count. A read in the same cycle
    // does not open a slot for a write, so the mesh never sees a
    // combinational path from ready_i to credit_o.
    assign full     = (count == FULL_COUNT);
    assign credit_o = !rst_i && !full;
    assign accept   = rx_i && credit_o;

    assign valid_o  = (count != '0);
    assign rd_en    = valid_o && ready_i;

    // The head is read straight out of storage. A flit written at edge k is
    // therefore visible right after edge k. The outputs are masked to 0
    // while the FIFO is empty.
    assign head     = mem[rd_ptr];
    assign data_o   = valid_o ? head[FLIT_SIZE-1:0] : '0;
    assign sop_o    = valid_o && head[FLIT_SIZE+1];
    assign eop_o    = valid_o && head[FLIT_SIZE];

    assign size_zero = (data_i == '0);
    assign rem_last  = (remaining == flit_t'(1));

    // Parser state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_HEADER;
        end else begin
            state <= state_next;
        end
    end

    // The parser only moves when a flit is accepted. Dropped flits are still
    // accepted, so a misaddressed packet drains from the mesh normally.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_sop     = 1'b0;
        wr_eop     = 1'b0;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;
        if (accept) begin
            case (state)
                ST_HEADER: begin
`ifdef EJECTOR_ADDR_CHECK_EN
                    if (data_i[15:0] == ADDR) begin
                        wr_en      = 1'b1;
                        wr_sop     = 1'b1;
                        state_next = ST_SIZE;
                    end else begin
                        state_next = ST_DROP_SIZE;
                    end
`else
                    wr_en      = 1'b1;
                    wr_sop     = 1'b1;
                    state_next = ST_SIZE;
`endif
                end
                ST_SIZE: begin
                    wr_en    = 1'b1;
                    rem_load = 1'b1;
                    if (size_zero) begin
                        // An empty packet ends on its size flit.
                        wr_eop     = 1'b1;
                        pkt_inc    = 1'b1;
                        state_next = ST_HEADER;
                    end else begin
                        state_next = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en   = 1'b1;
                    rem_dec = 1'b1;
                    if (rem_last) begin
                        wr_eop     = 1'b1;
                        pkt_inc    = 1'b1;
                        state_next = ST_HEADER;
                    end
                end
`ifdef EJECTOR_ADDR_CHECK_EN
                ST_DROP_SIZE: begin
                    rem_load = 1'b1;
                    if (size_zero) begin
                        err_inc    = 1'b1;
                        state_next = ST_HEADER;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
                ST_DROP: begin
                    rem_dec = 1'b1;
                    if (rem_last) begin
                        err_inc    = 1'b1;
                        state_next = ST_HEADER;
                    end
                end
`endif
                default: begin
                    state_next = ST_HEADER;
                end
            endcase
        end
    end

    // Remaining-flit counter, shared by the deliver and drop paths.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            remaining <= '0;
        end else if (rem_load) begin
            remaining <= data_i;
        end else if (rem_dec) begin
            remaining <= remaining - flit_t'(1);
        end
    end

    // FIFO storage holds only data and is not reset. Stale entries are
    // never visible, because valid_o masks the outputs.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= {wr_sop, wr_eop, data_i};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Delivered-packet counter; it counts when the eop flit enters the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_o <= '0;
        end else if (pkt_inc) begin
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end
    end

`ifdef EJECTOR_ADDR_CHECK_EN
    // Dropped-packet counter; it sticks at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (err_inc && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`else
    // Without address checking nothing is ever dropped. ADDR only feeds the
    // header compare, so here it is masked away to a constant zero.
    assign err_cnt_o = ADDR & 16'h0000;
`endif

endmodule

// File: tb/tb_hermes_boundary_ejector.sv
module tb_hermes_boundary_ejector;

    localparam int unsigned FW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] ADDR_T = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          credit_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [FW-1:0] data_o;
    logic          sop_o;
    logic          eop_o;
    logic [15:0]   pkt_cnt_o;
    logic [15:0]   err_cnt_o;

    hermes_boundary_ejector #(
        .FLIT_SIZE  (FW),
        .BUFFER_SIZE(DEPTH),
        .ADDR       (ADDR_T)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .data_i   (data_i),
        .credit_o (credit_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .sop_o    (sop_o),
        .eop_o    (eop_o),
        .pkt_cnt_o(pkt_cnt_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: the expected output stream as {sop, eop, flit},
    // the expected counters, and the flits of the packet being driven.
    logic [FW+1:0] exp_q[$];
    int            pkt_exp = 0;
    int            err_exp = 0;
    logic [FW-1:0] flits[$];

    int            ready_mode = 0;   // 0: hold off, 1: always ready, 2: random
    bit            mon_en = 1'b0;
    bit            hold_pend = 1'b0;
    logic [FW+2:0] hold_val = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Build one packet and record what the ejector must produce for it.
    task automatic build_pkt(input logic [FW-1:0] hdr, input int n,
                             input logic [FW-1:0] base, input bit rnd);
        bit keep;
        flits.delete();
        flits.push_back(hdr);
        flits.push_back(FW'(n));
        for (int i = 0; i < n; i++) begin
            flits.push_back(rnd ? FW'($urandom) : base + FW'(i));
        end
`ifdef EJECTOR_ADDR_CHECK_EN
        keep = (hdr[15:0] == ADDR_T);
`else
        keep = 1'b1;
`endif
        if (keep) begin
            for (int i = 0; i < flits.size(); i++) begin
                exp_q.push_back({(i == 0), (i == flits.size() - 1), flits[i]});
            end
            pkt_exp = (pkt_exp + 1) & 16'hFFFF;
        end else if (err_exp < 16'hFFFF) begin
            err_exp++;
        end
    endtask

    // Present one flit, waiting (bounded) for credit. The flit is taken at
    // the next rising edge.
    task automatic send_flit(input logic [FW-1:0] f, input int gap);
        int guard = 0;
        @(negedge clk);
        if (gap > 0) begin
            rx_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
        while (!credit_o && guard < 2000) begin
            rx_i = 1'b0;
            guard++;
            @(negedge clk);
        end
        if (!credit_o) check("credit_timeout", credit_o, 1);
        rx_i   = 1'b1;
        data_i = f;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_i = 1'b0;
    endtask

    task automatic send_all(input int gap_max);
        for (int i = 0; i < flits.size(); i++) begin
            send_flit(flits[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        idle();
    endtask

    task automatic set_ready(input int m);
        @(posedge clk);
        #1 ready_mode = m;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || valid_o) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", valid_o, 0);
    endtask

    // Output monitor: drives ready_i and checks each delivered flit against
    // the model queue. It also checks that the outputs stay stable while
    // they are stalled.
    always @(negedge clk) begin
        if (ready_mode == 2) ready_i = 1'($urandom_range(0, 1));
        else                 ready_i = (ready_mode == 1);
        if (!mon_en) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold_stable", {valid_o, sop_o, eop_o, data_o}, hold_val);
            if (valid_o && ready_i) begin
                check("out_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("out_flit", {sop_o, eop_o, data_o}, exp_q.pop_front());
                end
            end
            hold_pend = valid_o && !ready_i;
            hold_val  = {valid_o, sop_o, eop_o, data_o};
        end
    end

    initial begin
        // Reset state
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_sop", sop_o, 0);
        check("rst_eop", eop_o, 0);
        check("rst_pkt", pkt_cnt_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_credit", credit_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("credit_after_rst", credit_o, 1);
        mon_en = 1'b1;

        // Basic packet and one-cycle latency
        set_ready(1);
        build_pkt(32'h0000_0000, 2, 32'hA, 1'b0);
        send_flit(flits[0], 0);
        @(negedge clk);
        rx_i = 1'b0;
        check("lat_valid", valid_o, 1);
        check("lat_sop", sop_o, 1);
        check("lat_data", data_o, 0);
        for (int i = 1; i < flits.size(); i++) send_flit(flits[i], 0);
        idle();
        drain();
        check("basic_pkt_cnt", pkt_cnt_o, pkt_exp);

        // Size-0 packet; the counter updates the cycle after the eop flit
        build_pkt(32'h0000_0000, 0, 32'h0, 1'b0);
        send_flit(flits[0], 0);
        send_flit(flits[1], 0);
        check("size0_cnt_before", pkt_cnt_o, pkt_exp - 1);
        idle();
        check("size0_cnt_after", pkt_cnt_o, pkt_exp);
        drain();

        // Back-pressure: fill the FIFO, then release
        set_ready(0);
        build_pkt(32'h0000_0000, 8, 32'h100, 1'b0);
        for (int i = 0; i < DEPTH; i++) send_flit(flits[i], 0);
        @(negedge clk);
        rx_i = 1'b0;
        check("full_credit", credit_o, 0);
        check("full_head_sop", sop_o, 1);
        set_ready(1);
        @(negedge clk);
        check("full_credit_hold", credit_o, 0);
        @(negedge clk);
        check("credit_rise", credit_o, 1);
        for (int i = DEPTH; i < flits.size(); i++) send_flit(flits[i], 0);
        idle();
        drain();
        check("full_pkt_cnt", pkt_cnt_o, pkt_exp);

        // Foreign target, then a local one (dropped or delivered per build)
        build_pkt(32'h0000_0101, 3, 32'h20, 1'b0);
        send_all(0);
        build_pkt(32'h0000_0000, 1, 32'h30, 1'b0);
        send_all(0);
        drain();
        check("addr_err_cnt", err_cnt_o, err_exp);
        check("addr_pkt_cnt", pkt_cnt_o, pkt_exp);
        build_pkt(32'h0000_0101, 1, 32'h40, 1'b0);
        send_all(0);
        drain();
        check("addr2_err_cnt", err_cnt_o, err_exp);
        check("addr2_pkt_cnt", pkt_cnt_o, pkt_exp);

        // Reset partway through a packet
        set_ready(0);
        flits.delete();
        flits = '{32'h0, 32'h4, 32'h1, 32'h2, 32'h3, 32'h4};
        for (int i = 0; i < 3; i++) send_flit(flits[i], 0);
        @(posedge clk);
        #1 mon_en = 1'b0;
        @(negedge clk);
        rx_i  = 1'b0;
        rst_i = 1'b1;
        exp_q.delete();
        pkt_exp = 0;
        err_exp = 0;
        @(negedge clk);
        check("mrst_valid", valid_o, 0);
        check("mrst_data", data_o, 0);
        check("mrst_sop", sop_o, 0);
        check("mrst_eop", eop_o, 0);
        check("mrst_pkt", pkt_cnt_o, 0);
        check("mrst_err", err_cnt_o, 0);
        check("mrst_credit", credit_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("mrst_credit_up", credit_o, 1);
        check("mrst_empty", valid_o, 0);
        mon_en = 1'b1;
        set_ready(1);
        build_pkt(32'h0000_0000, 1, 32'h5, 1'b0);
        send_all(0);
        drain();
        check("mrst_pkt_after", pkt_cnt_o, pkt_exp);

        // Random traffic with random back-pressure and idle gaps
        set_ready(2);
        for (int p = 0; p < 30; p++) begin
            logic [FW-1:0] hdr;
            case ($urandom_range(0, 2))
                0:       hdr = 32'h0000_0000;
                1:       hdr = 32'h0000_0101;
                default: hdr = FW'($urandom);
            endcase
            build_pkt(hdr, int'($urandom_range(0, 12)), 32'h0, 1'b1);
            send_all(2);
        end
        set_ready(1);
        drain();
        check("rand_pkt_cnt", pkt_cnt_o, pkt_exp);
        check("rand_err_cnt", err_cnt_o, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hermes_boundary_ejector.md
# hermes_boundary_ejector

Receive-side endpoint for a Hermes mesh boundary port: the counterpart of the MA/APP injectors. Accepts credit-flow-controlled flits leaving the mesh at an edge port (e.g. 0x0000 south, 0x0101 north), frames them into packets, optionally filters on target address, and presents them on a valid/ready stream with start/end-of-packet tags. Instantiated once per boundary port that the testbench or an external peripheral consumes.

## Interface

- FLIT_SIZE, 32, flit width in bits
- BUFFER_SIZE, 8, flit FIFO depth; power of two, ≥ 2
- ADDR, 16'h0000, boundary router address this ejector represents
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- rx_i  in  1  flit valid from mesh port
- data_i  in  FLIT_SIZE  flit from mesh port
- credit_o  out  1  buffer space available; mesh may send when high
- valid_o  out  1  output flit valid
- ready_i  in  1  downstream accepts flit
- data_o  out  FLIT_SIZE  output flit
- sop_o  out  1  data_o is the header flit
- eop_o  out  1  data_o is the last flit of the packet
- pkt_cnt_o  out  16  packets delivered to FIFO; wraps 0xFFFF→0
- err_cnt_o  out  16  packets dropped on address mismatch; saturates at 0xFFFF

## Operation

- Packet format: flit 0 = header (target in data_i[15:0]), flit 1 = size N (payload flit count, full flit width, unsigned), flits 2..N+1 = payload.
- Input accept: flit taken when rx_i && credit_o. credit_o = !full, from registered FIFO count only (a same-cycle read does not enable a write when full).
- Parser FSM (advances only on accepted flit):
  - HEADER: match (or check disabled) → write flit with sop=1, go SIZE; mismatch → no write, go DROP_SIZE.
  - SIZE: write flit; load remaining counter = N; N==0 → tag eop=1, pkt_cnt++, go HEADER; else go PAYLOAD.
  - PAYLOAD: write flit, decrement; last (counter==1) → eop=1, pkt_cnt++, go HEADER.
  - DROP_SIZE: no write; load counter = N; N==0 → err_cnt++, go HEADER; else go DROP.
  - DROP: no write, decrement; last → err_cnt++, go HEADER.
- Dropped flits are still accepted (credit honoured) so the mesh never stalls on a bad packet.
- FIFO stores {sop, eop, data}; width FLIT_SIZE+2. Read when valid_o && ready_i.
- Single-flit-per-cycle in and out; simultaneous read and write allowed when not full.
- pkt_cnt_o increments on the cycle the eop flit is written, not when read out.

## Timing

- Reset (rst_i high at clk_i edge): FSM→HEADER, FIFO empty, counter 0, valid_o=0, data_o=0, sop_o=0, eop_o=0, pkt_cnt_o=0, err_cnt_o=0. credit_o=0 while rst_i high, 1 first cycle after.
- Reset mid-packet discards partial packet and FIFO contents; counters cleared; next flit is parsed as a header.
- Latency: flit accepted at edge k appears on data_o/valid_o after edge k (one cycle), if FIFO was empty.
- valid_o, data_o, sop_o, eop_o held stable while valid_o && !ready_i.
- Full: after BUFFER_SIZE unread flits credit_o drops the cycle after the filling write; rises the cycle after the first read.
- Counter wrap/saturate updates are registered, visible the cycle after the eop/last flit is accepted.

## Configuration

- EJECTOR_ADDR_CHECK_EN defined: HEADER compares data_i[15:0] to ADDR; mismatches take DROP path and count in err_cnt_o.
- Undefined: every header treated as a match; DROP_SIZE/DROP unreachable and omitted; err_cnt_o tied to 0.

## Test plan

- Reset then packet {0x0000, 2, 0xA, 0xB} with ready_i=1 → data_o 0x0000(sop),2,0xA,0xB(eop) on consecutive cycles starting 1 cycle after first rx; pkt_cnt_o=1.
- Size-0 packet {0x0000, 0} → two output flits, eop_o=1 on size flit; pkt_cnt_o=1.
- ready_i=0, BUFFER_SIZE=8, stream 10-flit packet → credit_o low after 8 accepts; raising ready_i drains all 10 in order, no loss or duplication.
- With EJECTOR_ADDR_CHECK_EN, packet to 0x0101 (size 3) then to 0x0000 (size 1) → first fully consumed, nothing output, err_cnt_o=1; second delivered, pkt_cnt_o=1.
- Assert rst_i after 3 of 6 flits of a packet → all outputs 0, FIFO empty; following packet {0x0000,1,0x5} delivered intact.
- Without EJECTOR_ADDR_CHECK_EN, packet to 0x0101 size 1 → delivered with sop/eop, err_cnt_o stays 0.
